// File: rtl/flappy_pkg.sv
// Shared bird/playfield definitions: state encoding, bus widths and default physics
// constants used by motion, renderer and collision blocks.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLYING = 2'd1,
    DEAD   = 2'd2
  } bird_state_t;

  localparam int Y_W      = 10;
  localparam int V_W      = 8;
  localparam int Y_START  = 240;
  localparam int Y_MIN    = 0;
  localparam int Y_MAX    = 440;
  localparam int GRAVITY  = 1;
  localparam int FLAP_VEL = -8;
  localparam int VEL_MAX  = 10;

endpackage

// File: rtl/bird_motion_if.sv
// Bird motion control/status bundle: event pulses in, registered position/state out.
interface bird_motion_if #(
  parameter int Y_W = flappy_pkg::Y_W,
  parameter int V_W = flappy_pkg::V_W
);

  logic                  flap_pulse;
  logic                  frame_tick;
  logic                  hit;
  logic                  restart;
  logic [Y_W-1:0]        bird_y;
  logic signed [V_W-1:0] bird_vel;
  logic [1:0]            state;
  logic                  dead;

  modport master (
    output flap_pulse, frame_tick, hit, restart,
    input  bird_y, bird_vel, state, dead
  );

  modport slave (
    input  flap_pulse, frame_tick, hit, restart,
    output bird_y, bird_vel, state, dead
  );

endinterface

// File: rtl/bird_motion.sv
// Vertical-motion engine: integrates gravity and flap impulse once per frame tick,
// clamps to ceiling/ground, and tracks IDLE/FLYING/DEAD. All outputs registered.
module bird_motion
  import flappy_pkg::*;
#(
  parameter int Y_W      = flappy_pkg::Y_W,
  parameter int V_W      = flappy_pkg::V_W,
  parameter int Y_START  = flappy_pkg::Y_START,
  parameter int Y_MIN    = flappy_pkg::Y_MIN,
  parameter int Y_MAX    = flappy_pkg::Y_MAX,
  parameter int GRAVITY  = flappy_pkg::GRAVITY,
  parameter int FLAP_VEL = flappy_pkg::FLAP_VEL,
  parameter int VEL_MAX  = flappy_pkg::VEL_MAX
) (
  input  logic         clk,
  input  logic         rst_n,
  bird_motion_if.slave bus
);

  localparam logic [Y_W-1:0]        L_YSTART = Y_W'(Y_START);
  localparam logic signed [V_W:0]   L_GRAV   = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]   L_VMAX   = (V_W+1)'(VEL_MAX);
  localparam logic signed [V_W-1:0] L_FLAP   = V_W'(FLAP_VEL);
  localparam logic signed [Y_W+1:0] L_YMIN   = (Y_W+2)'(Y_MIN);
  localparam logic signed [Y_W+1:0] L_YMAX   = (Y_W+2)'(Y_MAX);

  typedef struct packed {
    logic                  died;
    logic [Y_W-1:0]        y;
    logic signed [V_W-1:0] v;
  } step_t;

  // One frame of physics; velocity is widened by one bit so the gravity add
  // cannot wrap before the terminal-velocity clamp.
  function automatic step_t frame_step(input logic [Y_W-1:0]        y,
                                       input logic signed [V_W-1:0] v,
                                       input logic                  flap);
    step_t                 s;
    logic signed [V_W:0]   v_inc;
    logic signed [V_W-1:0] v_new;
    logic signed [Y_W+1:0] y_new;
    v_inc = (V_W+1)'(v) + L_GRAV;
    if (flap)
      v_new = L_FLAP;
    else if (v_inc > L_VMAX)
      v_new = L_VMAX[V_W-1:0];
    else
      v_new = v_inc[V_W-1:0];
    y_new  = $signed({2'b00, y}) + (Y_W+2)'(v_new);
    s.died = 1'b0;
    if (y_new <= L_YMIN) begin
      s.y = L_YMIN[Y_W-1:0];
      s.v = '0;
    end else if (y_new >= L_YMAX) begin
      s.y    = L_YMAX[Y_W-1:0];
      s.v    = '0;
      s.died = 1'b1;
    end else begin
      s.y = y_new[Y_W-1:0];
      s.v = v_new;
    end
    return s;
  endfunction

  bird_state_t           r_state;
  logic [Y_W-1:0]        r_y;
  logic signed [V_W-1:0] r_vel;
  logic                  r_flap_pend;
  logic                  r_dead;

  bird_state_t           w_nx_state;
  logic [Y_W-1:0]        w_nx_y;
  logic signed [V_W-1:0] w_nx_vel;
  logic                  w_nx_pend;
  step_t                 w_step;

  always_comb begin
    w_nx_state = r_state;
    w_nx_y     = r_y;
    w_nx_vel   = r_vel;
    w_nx_pend  = r_flap_pend;
    w_step     = frame_step(r_y, r_vel, r_flap_pend | bus.flap_pulse);
    case (r_state)
      IDLE: begin
        w_nx_y   = L_YSTART;
        w_nx_vel = '0;
        if (bus.flap_pulse) begin
          w_nx_state = FLYING;
          w_nx_pend  = 1'b1;
        end
      end
      FLYING: begin
        if (bus.frame_tick)
          w_nx_pend = 1'b0;
        else
          w_nx_pend = r_flap_pend | bus.flap_pulse;
        // A collision freezes the bird even if a frame update lands on the same edge.
        if (bus.hit) begin
          w_nx_state = DEAD;
        end else if (bus.frame_tick) begin
          w_nx_y   = w_step.y;
          w_nx_vel = w_step.v;
          if (w_step.died)
            w_nx_state = DEAD;
        end
      end
      DEAD: begin
        w_nx_pend = 1'b0;
        if (bus.restart) begin
          w_nx_state = IDLE;
          w_nx_y     = L_YSTART;
          w_nx_vel   = '0;
        end
      end
      default: begin
        w_nx_state = IDLE;
        w_nx_y     = L_YSTART;
        w_nx_vel   = '0;
        w_nx_pend  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_y         <= L_YSTART;
      r_vel       <= '0;
      r_flap_pend <= 1'b0;
      r_dead      <= 1'b0;
    end else begin
      r_state     <= w_nx_state;
      r_y         <= w_nx_y;
      r_vel       <= w_nx_vel;
      r_flap_pend <= w_nx_pend;
      r_dead      <= (w_nx_state == DEAD);
    end
  end

  assign bus.bird_y   = r_y;
  assign bus.bird_vel = r_vel;
  assign bus.state    = r_state;
  assign bus.dead     = r_dead;

endmodule

// File: tb/tb_bird_motion.sv
// Directed scenarios plus random event traffic against an integer model of the bird physics.
module tb_bird_motion;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  // Reference model state, plain integers.
  int m_state;
  int m_y;
  int m_v;
  bit m_pend;

  bird_motion_if #(.Y_W(10), .V_W(8)) bif ();

  bird_motion u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_y     = 240;
    m_v     = 0;
    m_pend  = 1'b0;
  endtask

  task automatic model_clock(input bit f, input bit t, input bit h, input bit r);
    int v2;
    int y2;
    case (m_state)
      0: if (f) begin
        m_state = 1;
        m_pend  = 1'b1;
      end
      1: begin
        if (h) begin
          m_state = 2;
          m_pend  = 1'b0;
        end else if (t) begin
          if (m_pend || f) v2 = -8;
          else v2 = (m_v + 1 > 10) ? 10 : m_v + 1;
          y2 = m_y + v2;
          if (y2 <= 0) begin
            m_y = 0;  m_v = 0;
          end else if (y2 >= 440) begin
            m_y = 440; m_v = 0; m_state = 2;
          end else begin
            m_y = y2; m_v = v2;
          end
          m_pend = 1'b0;
        end else if (f) begin
          m_pend = 1'b1;
        end
      end
      default: if (r) begin
        m_state = 0;
        m_y     = 240;
        m_v     = 0;
        m_pend  = 1'b0;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y"},     int'(bif.bird_y), m_y);
    check({tag, ".vel"},   int'($signed(bif.bird_vel)), m_v);
    check({tag, ".state"}, int'(bif.state), m_state);
    check({tag, ".dead"},  int'(bif.dead), (m_state == 2) ? 1 : 0);
  endtask

  task automatic cyc(input bit f, input bit t, input bit h, input bit r, input string tag);
    @(negedge clk);
    bif.flap_pulse = f;
    bif.frame_tick = t;
    bif.hit        = h;
    bif.restart    = r;
    @(posedge clk);
    model_clock(f, t, h, r);
    #1;
    check_all(tag);
  endtask

  initial begin
    int y_hold;
    n_cmp = 0;
    n_bad = 0;
    bif.flap_pulse = 1'b0;
    bif.frame_tick = 1'b0;
    bif.hit        = 1'b0;
    bif.restart    = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Start and arc
    cyc(0, 1, 0, 0, "idle_tick");
    cyc(1, 0, 0, 0, "idle_flap");
    cyc(0, 1, 0, 0, "arc1");
    check("arc1_y_const", int'(bif.bird_y), 232);
    check("arc1_v_const", int'($signed(bif.bird_vel)), -8);
    cyc(0, 1, 0, 0, "arc2");
    check("arc2_y_const", int'(bif.bird_y), 225);
    cyc(0, 1, 0, 0, "arc3");
    check("arc3_y_const", int'(bif.bird_y), 219);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, "arc_apex");
    check("apex_v_const", int'($signed(bif.bird_vel)), 0);

    // Terminal velocity
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 1, 0, 0, "fall");
      if (i >= 10) check("vmax_const", int'($signed(bif.bird_vel)), 10);
    end

    // Ground death, then events ignored while dead
    for (int i = 0; i < 40 && m_state == 1; i++) cyc(0, 1, 0, 0, "to_ground");
    check("ground_y_const", int'(bif.bird_y), 440);
    check("ground_dead_const", int'(bif.dead), 1);
    cyc(1, 1, 0, 0, "dead_ign1");
    cyc(1, 0, 0, 0, "dead_ign2");
    cyc(0, 1, 1, 0, "dead_ign3");
    cyc(0, 0, 0, 1, "restart1");
    check("restart1_y_const", int'(bif.bird_y), 240);

    // Ceiling clamp with flap coincident with tick
    cyc(1, 0, 0, 0, "c_start");
    for (int i = 0; i < 40 && m_y != 0; i++) cyc(1, 1, 0, 0, "to_ceiling");
    check("ceil_y_const", int'(bif.bird_y), 0);
    check("ceil_state_const", int'(bif.state), 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, "ceil_fall");
    cyc(1, 0, 0, 0, "triple1");
    cyc(1, 0, 0, 0, "triple2");
    cyc(1, 0, 0, 0, "triple3");
    cyc(0, 1, 0, 0, "triple_tick");
    check("triple_v_const", int'($signed(bif.bird_vel)), -8);
    cyc(0, 1, 0, 0, "triple_after");

    // Hit with coincident tick freezes position
    y_hold = m_y;
    cyc(0, 1, 1, 0, "hit_tick");
    check("hit_y_hold", int'(bif.bird_y), y_hold);
    check("hit_dead_const", int'(bif.dead), 1);
    cyc(0, 0, 0, 1, "restart2");

    // Asynchronous reset mid-flight, checked before any clock edge
    cyc(1, 0, 0, 0, "rf_flap");
    cyc(0, 1, 0, 0, "rf_t1");
    cyc(0, 1, 0, 0, "rf_t2");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Random event traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 80) == 0), ($urandom_range(0, 12) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bird_motion.md
Name: bird_motion

Overview:
Vertical-motion engine for the bird sprite. Consumes the one-clock click pulse from the mouse synchroniser (flap request) and a once-per-frame tick. Integrates gravity and flap impulse into a registered Y position and velocity. Runs a small IDLE/FLYING/DEAD state machine and feeds bird_y to the renderer and collision logic.

Parameters:
Y_W, 10, width of bird_y (pixels)
V_W, 8, width of signed velocity
Y_START, 240, bird_y in IDLE and after reset
Y_MIN, 0, ceiling row
Y_MAX, 440, ground row; reaching it kills the bird
GRAVITY, 1, velocity increment per frame (px/frame^2)
FLAP_VEL, -8, velocity loaded on a flap (signed)
VEL_MAX, 10, terminal downward velocity

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
flap_pulse  in  1  one-clock flap request, already synchronised to clk
frame_tick  in  1  one-clock pulse per video frame
hit  in  1  collision with pipe; level, sampled every clock
restart  in  1  one-clock pulse; leaves DEAD
bird_y  out  Y_W  current top row of the bird
bird_vel  out  V_W  current signed velocity
state  out  2  IDLE=0, FLYING=1, DEAD=2
dead  out  1  high while state==DEAD

Behaviour:
- Reset (rst_n low, async): state=IDLE, bird_y=Y_START, bird_vel=0, dead=0, flap_pend=0. Takes effect immediately mid-frame; there is no partial-update hazard.
- All outputs are registered. Updates occur on the clock edge where frame_tick=1 and are visible the next cycle.
- flap_pend:
  - Set by flap_pulse.
  - Cleared on every frame_tick.
  - Several flaps between ticks count as one.
  - A flap_pulse coincident with frame_tick is applied at that tick.
- IDLE:
  - bird_y=Y_START, bird_vel=0.
  - flap_pulse -> FLYING and sets flap_pend, so the first tick applies the flap.
  - frame_tick without a flap changes nothing.
- FLYING, on frame_tick:
  - Velocity: v_new = FLAP_VEL if flap_pend (or flap_pulse this cycle); else min(bird_vel + GRAVITY, VEL_MAX).
  - Position: y_new = bird_y + v_new, computed signed at Y_W+2 bits.
  - If y_new <= Y_MIN: bird_y=Y_MIN, bird_vel=0 (ceiling clamp, not fatal).
  - If y_new >= Y_MAX: bird_y=Y_MAX, bird_vel=0, state -> DEAD.
  - Otherwise bird_y=y_new, bird_vel=v_new.
- FLYING, hit:
  - hit=1 on any clock -> DEAD on the next edge; position frozen.
  - hit takes priority over a coincident frame_tick (no position update that cycle).
- DEAD:
  - Outputs hold; flap_pulse and frame_tick are ignored.
  - restart -> IDLE with bird_y=Y_START, bird_vel=0, flap_pend=0.
- restart outside DEAD is ignored.
- dead is a registered decode of state (dead = state==DEAD).
- Width rule: bird_vel is sign-extended before the add. No wrap-around is permitted; the clamps guarantee bird_y stays within Y_MIN..Y_MAX.

Decomposition:
- Shared package flappy_pkg:
  - enum bird_state_t {IDLE, FLYING, DEAD}
  - Y_W, V_W
  - default physics constants (GRAVITY, FLAP_VEL, VEL_MAX, Y_START, Y_MIN, Y_MAX), shared with the renderer and collision block.
- No sub-module. The per-frame step (velocity update + clamp) is a combinational function inside the module.

Test Plan:
- Reset mid-flight: assert rst_n=0 with bird_y=300 -> bird_y=240, bird_vel=0, state=IDLE asynchronously, before the next clk edge.
- Start and arc: from IDLE, flap_pulse then frame_tick -> y=232, v=-8. Next tick with no flap -> y=225, v=-7. Next -> y=219, v=-6.
- Terminal velocity: FLYING with v=0, 12 ticks without flap -> v reaches 10 on tick 10 and stays 10 on ticks 11 and 12.
- Ground death: y=436, v=9, tick -> y=440, v=0, state=DEAD, dead=1. Further ticks and flaps leave y=440.
- Ceiling clamp plus coincident events: y=5, flap_pulse in the same cycle as frame_tick -> y=0, v=0, still FLYING. Three flap_pulses within one frame produce a single v=-8.
- Hit and restart: hit=1 together with frame_tick at y=200 -> y stays 200, DEAD next cycle. restart -> IDLE, y=240, v=0.
